// File: rtl/modos_multicanal.sv
// modos_multicanal: per-channel debounced button FSM (short press / hold) driving saturating LED levels.
// Define MODOS_DECAY_EN to add the shared level-decay timer; without it levels move only on presses.
module modos_multicanal #(
  parameter int N_CH         = 4,
  parameter int LVL_W        = 2,
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int HOLD_CYCLES  = 250_000_000,
  parameter int DECAY_CYCLES = 500_000_000,
  parameter int TEST_DIV     = 10
) (
  input  logic                    clk,
  input  logic                    Bot_Reset,
  input  logic                    Bot_Test,
  input  logic [N_CH-1:0]         Bot_In,
  output logic [N_CH*LVL_W-1:0]   nivel,
  output logic [N_CH-1:0]         pulso_corto,
  output logic [N_CH-1:0]         pulso_largo,
  output logic [N_CH-1:0]         senal_5seg
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LIM    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM_N = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM_T = CNT_W'(HOLD_CYCLES / TEST_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_MAX    = '1;

  typedef enum logic [2:0] {IDLE, DB_ON, PRESSED, HELD, DB_OFF} state_t;

  logic [1:0]      rst_sync_q;
  logic            rst;
  logic [N_CH-1:0] in_meta_q, in_sync_q;
  logic            test_meta_q, test_sync_q;
  logic [CNT_W-1:0] hold_lim;
  logic            tick;

  state_t           st_q  [N_CH];
  state_t           st_d  [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [LVL_W-1:0] lvl_q [N_CH];
  logic [LVL_W-1:0] lvl_d [N_CH];
  logic [N_CH-1:0]  from_held_q, from_held_d;
  logic [N_CH-1:0]  corto_q, corto_d;
  logic [N_CH-1:0]  largo_q, largo_d;
  logic [N_CH-1:0]  senal_q, senal_d;

  // Reset asserts immediately but leaves on a clock edge, so no flop sees a runt release.
  always_ff @(posedge clk or posedge Bot_Reset) begin
    if (Bot_Reset) rst_sync_q <= 2'b11;
    else           rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_meta_q   <= '0;
      in_sync_q   <= '0;
      test_meta_q <= 1'b0;
      test_sync_q <= 1'b0;
    end else begin
      in_meta_q   <= Bot_In;
      in_sync_q   <= in_meta_q;
      test_meta_q <= Bot_Test;
      test_sync_q <= test_meta_q;
    end
  end

  assign hold_lim = test_sync_q ? HOLD_LIM_T : HOLD_LIM_N;

`ifdef MODOS_DECAY_EN
  localparam int DEC_W = $clog2(DECAY_CYCLES + 1);
  localparam logic [DEC_W-1:0] DEC_LIM_N = DEC_W'(DECAY_CYCLES - 1);
  localparam logic [DEC_W-1:0] DEC_LIM_T = DEC_W'(DECAY_CYCLES / TEST_DIV - 1);

  logic [DEC_W-1:0] dec_q, dec_d;

  always_comb begin
    tick  = dec_q >= (test_sync_q ? DEC_LIM_T : DEC_LIM_N);
    dec_d = tick ? '0 : dec_q + DEC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_q <= '0;
    else     dec_q <= dec_d;
  end
`else
  // No decay timer: the tick is constantly low and DECAY_CYCLES only keeps the interface uniform.
  assign tick = (DECAY_CYCLES < 0);
`endif

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]        = st_q[i];
      cnt_d[i]       = cnt_q[i];
      from_held_d[i] = from_held_q[i];
      corto_d[i]     = 1'b0;
      largo_d[i]     = 1'b0;
      case (st_q[i])
        IDLE: begin
          if (in_sync_q[i]) begin
            st_d[i]  = DB_ON;
            cnt_d[i] = '0;
          end
        end
        DB_ON: begin
          if (!in_sync_q[i]) begin
            st_d[i] = IDLE;
          end else if (cnt_q[i] == DEB_LIM) begin
            st_d[i]  = PRESSED;
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!in_sync_q[i]) begin
            st_d[i]        = DB_OFF;
            from_held_d[i] = 1'b0;
            cnt_d[i]       = '0;
          end else if (cnt_q[i] >= hold_lim) begin
            st_d[i]    = HELD;
            largo_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!in_sync_q[i]) begin
            st_d[i]        = DB_OFF;
            from_held_d[i] = 1'b1;
            cnt_d[i]       = '0;
          end
        end
        DB_OFF: begin
          // A bounce during release returns to the previous pressed state; hold timing restarts.
          if (in_sync_q[i]) begin
            st_d[i]  = from_held_q[i] ? HELD : PRESSED;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DEB_LIM) begin
            st_d[i]    = IDLE;
            corto_d[i] = !from_held_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: st_d[i] = IDLE;
      endcase

      senal_d[i] = (st_d[i] == HELD) || ((st_d[i] == DB_OFF) && from_held_d[i]);

      // Hold refill wins; otherwise a short press and a decay tick in the same cycle cancel.
      lvl_d[i] = lvl_q[i];
      if (largo_d[i]) begin
        lvl_d[i] = LVL_MAX;
      end else if (corto_d[i] && !tick) begin
        if (lvl_q[i] != LVL_MAX) lvl_d[i] = lvl_q[i] + LVL_W'(1);
      end else if (!corto_d[i] && tick) begin
        if (lvl_q[i] != '0) lvl_d[i] = lvl_q[i] - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
        lvl_q[i] <= '0;
      end
      from_held_q <= '0;
      corto_q     <= '0;
      largo_q     <= '0;
      senal_q     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        lvl_q[i] <= lvl_d[i];
      end
      from_held_q <= from_held_d;
      corto_q     <= corto_d;
      largo_q     <= largo_d;
      senal_q     <= senal_d;
    end
  end

  always_comb begin
    nivel = '0;
    for (int i = 0; i < N_CH; i++) nivel[i*LVL_W +: LVL_W] = lvl_q[i];
  end

  assign pulso_corto = corto_q;
  assign pulso_largo = largo_q;
  assign senal_5seg  = senal_q;

endmodule

// File: tb/tb_modos_multicanal.sv
// Bench for modos_multicanal: directed scenarios plus random button traffic against a run-length reference model.
module tb_modos_multicanal;

  localparam int N = 4, LW = 2, DEB = 4, HOLD = 40, DECAY = 100, DIV = 4;

  logic            clk = 1'b0;
  logic            Bot_Reset = 1'b0;
  logic            Bot_Test = 1'b0;
  logic [N-1:0]    Bot_In = '0;
  logic [N*LW-1:0] nivel;
  logic [N-1:0]    pulso_corto, pulso_largo, senal_5seg;

  modos_multicanal #(
    .N_CH(N), .LVL_W(LW), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .DECAY_CYCLES(DECAY), .TEST_DIV(DIV)
  ) dut (
    .clk(clk), .Bot_Reset(Bot_Reset), .Bot_Test(Bot_Test), .Bot_In(Bot_In),
    .nivel(nivel), .pulso_corto(pulso_corto), .pulso_largo(pulso_largo), .senal_5seg(senal_5seg)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: debounce as "N+1 equal consecutive synchronised samples", hold as pressed age.
  bit m_p1[N], m_p2[N], m_prev[N], m_on[N], m_held[N], m_pc[N], m_pl[N];
  int m_run[N], m_age[N], m_lvl[N];
  bit m_t1, m_t2;
  int m_timer, m_rst_hold;

  // Observed-event bookkeeping for the directed checks.
  int n_pc[N], n_pl[N], lvl_at_pl[N];
  bit ev_any;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_p1[i] = 0; m_p2[i] = 0; m_prev[i] = 0; m_on[i] = 0; m_held[i] = 0;
      m_pc[i] = 0; m_pl[i] = 0; m_run[i] = 0; m_age[i] = 0; m_lvl[i] = 0;
    end
    m_t1 = 0; m_t2 = 0; m_timer = 0; m_rst_hold = 2;
  endfunction

  function automatic void model_edge();
    bit ts, s, tick;
    int hold_t, dec_t, dn;
    if (Bot_Reset) return;
    if (m_rst_hold > 0) begin
      m_rst_hold--;
      return;
    end
    ts = m_t2; m_t2 = m_t1; m_t1 = Bot_Test;
    hold_t = ts ? HOLD / DIV : HOLD;
    dec_t  = ts ? DECAY / DIV : DECAY;
    tick   = (m_timer + 1 >= dec_t);
    m_timer = tick ? 0 : m_timer + 1;
`ifdef MODOS_DECAY_EN
    dn = tick ? 1 : 0;
`else
    dn = 0;
`endif
    for (int i = 0; i < N; i++) begin
      s = m_p2[i]; m_p2[i] = m_p1[i]; m_p1[i] = Bot_In[i];
      m_run[i] = (s == m_prev[i]) ? m_run[i] + 1 : 1;
      m_prev[i] = s;
      m_pc[i] = 0; m_pl[i] = 0;
      if (!m_on[i]) begin
        if (s && m_run[i] == DEB + 1) begin
          m_on[i] = 1; m_held[i] = 0; m_age[i] = 0;
        end
      end else if (!s) begin
        if (m_run[i] == DEB + 1) begin
          m_on[i] = 0; m_pc[i] = !m_held[i]; m_held[i] = 0;
        end
      end else if (!m_held[i]) begin
        if (m_run[i] == 1) m_age[i] = 0;
        else begin
          m_age[i]++;
          if (m_age[i] >= hold_t) begin
            m_held[i] = 1; m_pl[i] = 1;
          end
        end
      end
      if (m_pl[i]) m_lvl[i] = (1 << LW) - 1;
      else begin
        m_lvl[i] = m_lvl[i] + int'(m_pc[i]) - dn;
        if (m_lvl[i] > (1 << LW) - 1) m_lvl[i] = (1 << LW) - 1;
        if (m_lvl[i] < 0) m_lvl[i] = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N*LW-1:0] en;
    logic [N-1:0] ec, el, es;
    for (int i = 0; i < N; i++) begin
      en[i*LW +: LW] = LW'(m_lvl[i]);
      ec[i] = m_pc[i];
      el[i] = m_pl[i];
      es[i] = m_on[i] && m_held[i];
    end
    chk("nivel", 32'(nivel), 32'(en));
    chk("pulso_corto", 32'(pulso_corto), 32'(ec));
    chk("pulso_largo", 32'(pulso_largo), 32'(el));
    chk("senal_5seg", 32'(senal_5seg), 32'(es));
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      for (int i = 0; i < N; i++) begin
        if (pulso_corto[i]) n_pc[i]++;
        if (pulso_largo[i]) begin
          n_pl[i]++;
          lvl_at_pl[i] = int'(nivel[i*LW +: LW]);
        end
      end
      if (|{pulso_corto, pulso_largo, senal_5seg}) ev_any = 1;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      n_pc[i] = 0; n_pl[i] = 0; lvl_at_pl[i] = -1;
    end
    ev_any = 0;
  endtask

  task automatic do_reset();
    Bot_Reset = 1;
    model_reset();
    step(3);
    Bot_Reset = 0;
    clr();
  endtask

  int lat;
  int waited;
  int rem[N];
  logic [N*LW-1:0] exp_lv;

  initial begin
    clr();
    model_reset();
    Bot_In = '1;
    #1;
    Bot_Reset = 1;
    #1;
    chk("reset_nivel", 32'(nivel), 32'h0);
    chk("reset_corto", 32'(pulso_corto), 32'h0);
    chk("reset_largo", 32'(pulso_largo), 32'h0);
    chk("reset_senal", 32'(senal_5seg), 32'h0);
    step(3);
    Bot_Reset = 0;
    clr();
    step(8);
    chk("t1_no_early_event", 32'(ev_any), 32'h0);

    // Short presses on channel 0
    do_reset();
    Bot_In = '0;
    Bot_In[0] = 1; step(15); Bot_In[0] = 0; step(15);
    chk("t2_first_level", 32'(nivel[1:0]), 32'h1);
    for (int p = 0; p < 4; p++) begin
      Bot_In[0] = 1; step(15); Bot_In[0] = 0; step(15);
    end
    chk("t2_corto_count", 32'(n_pc[0]), 32'd5);
    chk("t2_largo_count", 32'(n_pl[0]), 32'd0);
`ifndef MODOS_DECAY_EN
    chk("t2_saturated", 32'(nivel[1:0]), 32'h3);
`endif

    // Glitch on channel 1
    clr();
    Bot_In[1] = 1; step(3); Bot_In[1] = 0; step(12);
    chk("t3_corto", 32'(n_pc[1]), 32'd0);
    chk("t3_largo", 32'(n_pl[1]), 32'd0);
    chk("t3_level", 32'(nivel[3:2]), 32'h0);

    // Hold on channel 2
    clr();
    Bot_In[2] = 1; step(80);
    chk("t4_largo_count", 32'(n_pl[2]), 32'd1);
    chk("t4_level_on_hold", 32'(lvl_at_pl[2]), 32'd3);
    chk("t4_senal_held", 32'(senal_5seg[2]), 32'h1);
    Bot_In[2] = 0; step(12);
    chk("t4_senal_released", 32'(senal_5seg[2]), 32'h0);
    chk("t4_no_corto", 32'(n_pc[2]), 32'd0);

    // Test mode: accelerated hold on channel 3
    clr();
    Bot_Test = 1; step(3);
    Bot_In[3] = 1;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      if (pulso_largo[3]) begin
        lat = k;
        break;
      end
    end
    chk("t5_hold_latency", 32'(lat), 32'd17);
    Bot_In[3] = 0; step(12);
    step(60);
    Bot_Test = 0;

    // Decay of all channels from full
    do_reset();
    Bot_In = '1; step(55); Bot_In = '0; step(300);
`ifdef MODOS_DECAY_EN
    exp_lv = '0;
`else
    exp_lv = '1;
`endif
    chk("t6_levels_after_idle", 32'(nivel), 32'(exp_lv));

    // Short press whose pulse coincides with a decay tick
    do_reset();
    Bot_In[0] = 1; step(50); Bot_In[0] = 0; step(60);
    waited = 0;
    while ((DECAY - m_timer) != 17 && waited < 300) begin
      step(1);
      waited++;
    end
    chk("t6_align_timeout", 32'(waited < 300), 32'h1);
    Bot_In[0] = 1; step(10); Bot_In[0] = 0; step(7);
    chk("t6_corto_on_tick", 32'(pulso_corto[0]), 32'h1);
`ifdef MODOS_DECAY_EN
    chk("t6_level_unchanged", 32'(nivel[1:0]), 32'h2);
`else
    chk("t6_level_unchanged", 32'(nivel[1:0]), 32'h3);
`endif

    // Random traffic, including a reset in the middle of activity
    do_reset();
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          Bot_In[i] = !Bot_In[i];
          rem[i] = $urandom_range(1, 60);
        end
        rem[i]--;
      end
      if ($urandom_range(0, 149) == 0) Bot_Test = !Bot_Test;
      if (k == 1000) begin
        Bot_Reset = 1;
        model_reset();
        step(3);
        Bot_Reset = 0;
      end
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
